// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: op codes and FSM states.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MTHI = 3'b000,
      OP_MTLO = 3'b001,
      OP_MULT = 3'b010,
      OP_DIV  = 3'b011,
      OP_MADD = 3'b100,
      OP_MSUB = 3'b101,
      OP_RSV6 = 3'b110,
      OP_RSV7 = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/mult_div_unit_abs_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module mdu_abs_neg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic             neg,
   output logic [WIDTH-1:0] y
);

   assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI and LO registers,
// with MADD/MSUB accumulate and a start/busy/done handshake.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             sin,
   input  logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] in_2,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e               state;
   op_e                  op_q;
   op_e                  op_in;
   logic                 sign_res;
   logic                 sign_rem;
   logic                 dz_q;
   logic [CNT_W-1:0]     cnt;
   logic [WIDTH-1:0]     mcand;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_step;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_diff;
   logic [WIDTH-1:0]     mag_1;
   logic [WIDTH-1:0]     mag_2;
   logic [2*WIDTH-1:0]   prod_s;
   logic [WIDTH-1:0]     quo_s;
   logic [WIDTH-1:0]     rem_s;
   logic [2*WIDTH-1:0]   fix_hilo;

   assign op_in = op_e'(op);
   assign busy  = (state != S_IDLE);

   mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_1 (.a(in_1), .neg(sin & in_1[WIDTH-1]), .y(mag_1));
   mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_2 (.a(in_2), .neg(sin & in_2[WIDTH-1]), .y(mag_2));

   mdu_abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.a(acc), .neg(sign_res), .y(prod_s));
   mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (.a(acc[WIDTH-1:0]), .neg(sign_res), .y(quo_s));
   mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (.a(acc[2*WIDTH-1:WIDTH]), .neg(sign_rem), .y(rem_s));

   // acc holds {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
      div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mcand};
      if (op_q == OP_DIV) begin
         acc_step = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   // hi/lo are frozen while busy, so they serve directly as the latched accumulate base
   always_comb begin
      fix_hilo = {hi, lo};
      case (op_q)
         OP_MULT: fix_hilo = prod_s;
         OP_DIV:  fix_hilo = dz_q ? {acc[WIDTH-1:0], {WIDTH{1'b1}}} : {rem_s, quo_s};
         OP_MADD: fix_hilo = {hi, lo} + prod_s;
         OP_MSUB: fix_hilo = {hi, lo} - prod_s;
         default: fix_hilo = {hi, lo};
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         op_q     <= OP_MTHI;
         sign_res <= 1'b0;
         sign_rem <= 1'b0;
         dz_q     <= 1'b0;
         cnt      <= '0;
         mcand    <= '0;
         acc      <= '0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  div_zero <= 1'b0;
                  op_q     <= op_in;
                  cnt      <= '0;
                  sign_res <= sin & (in_1[WIDTH-1] ^ in_2[WIDTH-1]);
                  sign_rem <= sin & in_1[WIDTH-1];
                  mcand    <= mag_2;
                  acc      <= {{WIDTH{1'b0}}, mag_1};
                  dz_q     <= 1'b0;
                  case (op_in)
                     OP_MTHI: begin
                        hi   <= in_1;
                        done <= 1'b1;
                     end
                     OP_MTLO: begin
                        lo   <= in_2;
                        done <= 1'b1;
                     end
                     OP_DIV: begin
                        if (in_2 == '0) begin
                           dz_q  <= 1'b1;
                           acc   <= {{WIDTH{1'b0}}, in_1};
                           state <= S_FIX;
                        end else begin
                           state <= S_CALC;
                        end
                     end
                     OP_MULT, OP_MADD, OP_MSUB: state <= S_CALC;
                     default: done <= 1'b1;
                  endcase
               end
            end
            S_CALC: begin
               acc <= acc_step;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
            end
            S_FIX: begin
               {hi, lo} <= fix_hilo;
               if (dz_q) div_zero <= 1'b1;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;

   localparam logic [2:0] MTHI = 3'b000, MTLO = 3'b001, MULT = 3'b010, DIV = 3'b011,
                          MADD = 3'b100, MSUB = 3'b101, RSV6 = 3'b110;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic        sin = 1'b0;
   logic [31:0] in_1 = '0;
   logic [31:0] in_2 = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .sin(sin),
      .in_1(in_1), .in_2(in_2), .busy(busy), .done(done), .div_zero(div_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // lat = edges after the accepting edge until done is seen; bounded
   task automatic do_op(input logic [2:0] o, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output int bcnt);
      start = 1'b1; op = o; sin = s; in_1 = a; in_2 = b;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; bcnt = 0;
      while (!done && lat < 200) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
         errors++; $display("FAIL reset_state got %h exp 0", {busy, done, div_zero, hi, lo});
      end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mult();
      int lat, bc;
      do_op(MULT, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL mulu_latency got %0d exp 33", lat); end
      checks++;
      if (bc !== 33) begin errors++; $display("FAIL mulu_busy_cycles got %0d exp 33", bc); end
      checks++;
      if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
         errors++; $display("FAIL mulu_result got %h exp fffffffe00000001", {hi, lo});
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL mulu_done_pulse got done=%b busy=%b exp 0 0", done, busy);
      end
      do_op(MULT, 1'b1, 32'hFFFFFFFD, 32'd4, lat, bc);
      checks++;
      if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF4) begin
         errors++; $display("FAIL mul_neg got %h exp fffffffffffffff4", {hi, lo});
      end
      do_op(MULT, 1'b1, 32'h80000000, 32'h80000000, lat, bc);
      checks++;
      if ({hi, lo} !== 64'h40000000_00000000) begin
         errors++; $display("FAIL mul_minneg got %h exp 4000000000000000", {hi, lo});
      end
   endtask

   task automatic test_div();
      int lat, bc;
      do_op(DIV, 1'b1, 32'hFFFFFFF9, 32'd2, lat, bc);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
      checks++;
      if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
         errors++; $display("FAIL div_signed got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo);
      end
      do_op(DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bc);
      checks++;
      if (lo !== 32'h80000000 || hi !== 32'h0 || div_zero !== 1'b0 || lat !== 33) begin
         errors++; $display("FAIL div_overflow got hi=%h lo=%h dz=%b lat=%0d exp 0 80000000 0 33",
                            hi, lo, div_zero, lat);
      end
      do_op(DIV, 1'b0, 32'd100, 32'd7, lat, bc);
      checks++;
      if (lo !== 32'd14 || hi !== 32'd2) begin
         errors++; $display("FAIL divu got hi=%0d lo=%0d exp hi=2 lo=14", hi, lo);
      end
   endtask

   task automatic test_div_zero();
      int lat, bc;
      do_op(DIV, 1'b0, 32'h1234, 32'd0, lat, bc);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d exp 1", lat); end
      checks++;
      if (lo !== 32'hFFFFFFFF || hi !== 32'h1234 || div_zero !== 1'b1) begin
         errors++; $display("FAIL dz_result got hi=%h lo=%h dz=%b exp 1234 ffffffff 1", hi, lo, div_zero);
      end
      do_op(MTLO, 1'b0, 32'd0, 32'd5, lat, bc);
      checks++;
      if (div_zero !== 1'b0 || lo !== 32'd5 || hi !== 32'h1234 || lat !== 0 || bc !== 0) begin
         errors++; $display("FAIL dz_clear got dz=%b hi=%h lo=%h lat=%0d exp 0 1234 5 0", div_zero, hi, lo, lat);
      end
   endtask

   task automatic test_accumulate();
      int lat, bc;
      do_op(MTHI, 1'b1, 32'd0, 32'd99, lat, bc);
      do_op(MTLO, 1'b1, 32'd99, 32'd10, lat, bc);
      checks++;
      if (hi !== 32'd0 || lo !== 32'd10) begin
         errors++; $display("FAIL mthi_mtlo got hi=%h lo=%h exp 0 a", hi, lo);
      end
      do_op(MADD, 1'b1, 32'hFFFFFFFD, 32'd4, lat, bc);
      checks++;
      if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFE || lat !== 33) begin
         errors++; $display("FAIL madd got %h lat=%0d exp fffffffffffffffe 33", {hi, lo}, lat);
      end
      do_op(MSUB, 1'b1, 32'hFFFFFFFD, 32'd4, lat, bc);
      checks++;
      if (hi !== 32'd0 || lo !== 32'd10) begin
         errors++; $display("FAIL msub got hi=%h lo=%h exp 0 a", hi, lo);
      end
   endtask

   task automatic test_reserved();
      int lat, bc;
      do_op(RSV6, 1'b0, 32'hAAAAAAAA, 32'h55555555, lat, bc);
      checks++;
      if (lat !== 0 || bc !== 0 || hi !== 32'd0 || lo !== 32'd10) begin
         errors++; $display("FAIL reserved got lat=%0d busy=%0d hi=%h lo=%h exp 0 0 0 a", lat, bc, hi, lo);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      start = 1'b1; op = DIV; sin = 1'b0; in_1 = 32'd100; in_2 = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op = MTHI; in_1 = 32'hDEADBEEF;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL collision_mid got done=%b busy=%b exp 0 1", done, busy);
      end
      lat = 0;
      while (!done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (hi !== 32'd2 || lo !== 32'd14) begin
         errors++; $display("FAIL collision_result got hi=%h lo=%h exp 2 e", hi, lo);
      end
   endtask

   task automatic test_async_reset();
      int lat, bc;
      start = 1'b1; op = MULT; sin = 1'b0; in_1 = 32'hFFFFFFFF; in_2 = 32'hFFFFFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
         errors++; $display("FAIL async_reset got busy=%b hi=%h lo=%h done=%b exp 0 0 0 0", busy, hi, lo, done);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      do_op(MULT, 1'b0, 32'd3, 32'd5, lat, bc);
      checks++;
      if (lo !== 32'd15 || hi !== 32'd0 || lat !== 33) begin
         errors++; $display("FAIL post_reset_mul got hi=%h lo=%h lat=%0d exp 0 f 33", hi, lo, lat);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_accumulate();
      test_reserved();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised successor to the single-cycle HI/LO multiply/divide register. It provides an iterative shift-add multiplier and a restoring divider that share one datapath, an accumulate mode (MADD/MSUB), and a start/busy/done handshake so the pipeline can stall on a long operation. It sits beside the ALU in the execute stage and owns the architectural HI and LO registers.

Parameters:
WIDTH, 32, operand and HI/LO width; legal values are even integers from 8 to 64.
CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, never overridden.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (reset=0 clears all state)
start  in  1  request; sampled only in IDLE
op  in  3  000 MTHI, 001 MTLO, 010 MULT, 011 DIV, 100 MADD, 101 MSUB, 110/111 reserved
sin  in  1  1 = signed operands, 0 = unsigned (MULT/DIV/MADD/MSUB only)
in_1  in  WIDTH  rs operand / dividend / MTHI source
in_2  in  WIDTH  rt operand / divisor / MTLO source
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse on the edge that HI/LO take a new value
div_zero  out  1  sticky flag, set by a DIV with in_2=0, cleared by the next accepted start
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE; hi, lo, busy, done, div_zero and all internal registers are 0. An operation in flight is aborted and no partial result is written.
- FSM states are IDLE, CALC and FIX.
- IDLE + start + MTHI/MTLO: hi<=in_1 or lo<=in_2 at the same edge, done=1 the next cycle, state stays IDLE, busy never rises.
- IDLE + start + MULT/DIV/MADD/MSUB (edge E0): latch magnitudes |in_1| and |in_2| (when sin=1), latch the result sign, the op, and the current {hi,lo} for accumulate; clear counter; go to CALC. busy=1 from E0.
- CALC: one iteration per edge, WIDTH edges in total. The multiplier is 2*WIDTH shift-add on the magnitudes. The divider is restoring, one quotient bit per edge. Go to FIX when counter==WIDTH-1.
- FIX (edge E0+WIDTH+1): negate the result if the sign is negative. Then write:
  - MULT: {hi,lo}<=product.
  - DIV: lo<=quotient, hi<=remainder. Remainder takes the sign of the dividend; quotient truncates toward zero.
  - MADD: {hi,lo}<=latched {hi,lo}+product.
  - MSUB: {hi,lo}<=latched {hi,lo}-product.
  - Accumulate arithmetic is modulo 2^(2*WIDTH).
  - Then done=1 for one cycle, state goes to IDLE, busy=0.
- Total latency is WIDTH+1 edges after the accepting edge. hi/lo hold their old values throughout CALC.
- start while busy is ignored and not queued. Reserved op codes are accepted as no-ops: done pulses and hi/lo are unchanged.
- Divide by zero: skip CALC and go straight to FIX. lo<=all ones, hi<=in_1 (dividend unchanged), div_zero<=1. Latency is 1 edge to FIX plus 1 edge to write.
- Signed overflow (-2^(WIDTH-1) / -1): lo<=-2^(WIDTH-1), hi<=0, div_zero stays 0, normal latency.
- The most-negative operand in signed MULT has magnitude 2^(WIDTH-1). The magnitude registers are WIDTH bits unsigned, so no overflow occurs.
- sin is ignored for MTHI and MTLO.

Decomposition:
- Package mdu_pkg: op_e enum (the 3-bit codes above) and state_e enum (IDLE, CALC, FIX).
- Sub-module mdu_abs_neg (WIDTH param): conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
- The top level holds the FSM, counter and shared shift datapath.

Test Plan:
- Unsigned MULT: WIDTH=32, in_1=0xFFFFFFFF, in_2=0xFFFFFFFF, sin=0 -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001, done one cycle, busy high for 33 cycles.
- Signed DIV: in_1=-7 (0xFFFFFFF9), in_2=2, sin=1 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); overflow case 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU in_1=0x1234, in_2=0 -> 2 edges later lo=0xFFFFFFFF, hi=0x1234, div_zero=1; next MTLO start clears div_zero.
- MADD signed: hi=0, lo=10 via MTHI/MTLO, then MADD in_1=-3, in_2=4 -> {hi,lo}=0xFFFFFFFF_FFFFFFFE; MSUB with same operands restores lo=10, hi=0.
- Busy collision: start DIVU, assert start with MTHI on cycle 5 -> ignored; hi equals the remainder at completion, not the MTHI value.
- Async reset mid-operation: reset=0 at CALC cycle 10 of MULT -> immediately busy=0, hi=lo=0; after release, a new MULTU 3*5 gives lo=15, hi=0.
